// File: rtl/loader_mem_writer.sv
// Byte-write buffer between the game loader and the SDRAM controller port.
// Queues byte writes, merges adjacent even/odd pairs, and issues 16-bit req/ack writes.
module loader_mem_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 22
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          in_ready,
  output logic          sd_req,
  output logic [AW-2:0] sd_addr,
  output logic [15:0]   sd_din,
  output logic [1:0]    sd_be,
  input  logic          sd_ack,
  output logic          busy,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [7:0]    ent_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [CW-1:0] count_q, count_d, pop_cnt;
  state_t        state_q, state_d;
  logic          sd_req_q, sd_req_d;
  logic [AW-2:0] sd_addr_q, sd_addr_d;
  logic [15:0]   sd_din_q, sd_din_d;
  logic [1:0]    sd_be_q, sd_be_d;
  logic          pair_q, pair_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          full, push, pop, merge;
  logic [AW-1:0] head_addr, second_addr, head_inc;
  logic [7:0]    head_data, second_data;

  assign full        = (count_q == FULL_COUNT);
  assign in_ready    = resetn & ~full;
  assign push        = wr_en & in_ready;
  assign pop         = (state_q == ISSUE) & sd_ack;

  assign rd_ptr_nx   = rd_ptr_q + PW'(1);
  assign head_addr   = ent_addr_q[rd_ptr_q];
  assign head_data   = ent_data_q[rd_ptr_q];
  assign second_addr = ent_addr_q[rd_ptr_nx];
  assign second_data = ent_data_q[rd_ptr_nx];
  assign head_inc    = head_addr + AW'(1);

  // Only pairs already queued merge; an all-ones head is odd so it never wraps into a pair.
  assign merge = (count_q >= CW'(2)) & ~head_addr[0] & (second_addr == head_inc);

  always_comb begin
    pop_cnt = '0;
    if (pop) begin
      pop_cnt = pair_q ? CW'(2) : CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    sd_req_d  = sd_req_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_be_d   = sd_be_q;
    pair_d    = pair_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = ISSUE;
          sd_req_d  = 1'b1;
          sd_addr_d = head_addr[AW-1:1];
          if (merge) begin
            sd_be_d  = 2'b11;
            sd_din_d = {second_data, head_data};
            pair_d   = 1'b1;
          end else begin
            sd_be_d  = head_addr[0] ? 2'b10 : 2'b01;
            sd_din_d = {head_data, head_data};
            pair_d   = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          state_d  = IDLE;
          sd_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_d    = count_q + CW'(push) - pop_cnt;
  assign busy_d     = (count_d != '0) | (state_d == ISSUE);
  assign overflow_d = overflow_q | (wr_en & full);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sd_req_q   <= 1'b0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      sd_be_q    <= '0;
      pair_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sd_req_q   <= sd_req_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      sd_be_q    <= sd_be_d;
      pair_q     <= pair_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + PW'(push);
      rd_ptr_q   <= rd_ptr_q + PW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= wr_addr;
      ent_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Gate with resetn so the outputs are quiet for the whole reset cycle.
  assign sd_req   = sd_req_q & resetn;
  assign busy     = busy_q & resetn;
  assign overflow = overflow_q & resetn;
  assign sd_addr  = sd_addr_q;
  assign sd_din   = sd_din_q;
  assign sd_be    = sd_be_q;

endmodule

// File: tb/tb_loader_mem_writer.sv
// Directed bench for loader_mem_writer: an SDRAM responder model logs every
// acknowledged write, and each test compares the log against hand-computed values.
module tb_loader_mem_writer;

  localparam int DEPTH = 8;
  localparam int AW    = 22;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          in_ready;
  logic          sd_req;
  logic [AW-2:0] sd_addr;
  logic [15:0]   sd_din;
  logic [1:0]    sd_be;
  logic          sd_ack = 1'b0;
  logic          busy;
  logic          overflow;

  int n_vec = 0;
  int n_bad = 0;

  int ack_delay  = 1;
  bit ack_enable = 1'b1;
  int req_cycles = 0;
  int stray_req  = 0;
  int stray_done = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_din[$];
  logic [31:0] log_be[$];

  loader_mem_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .in_ready (in_ready),
    .sd_req   (sd_req),
    .sd_addr  (sd_addr),
    .sd_din   (sd_din),
    .sd_be    (sd_be),
    .sd_ack   (sd_ack),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // SDRAM responder: acks ack_delay cycles after it first sees sd_req, logging each write.
  always @(negedge clk) begin
    if (!resetn) begin
      sd_ack     = 1'b0;
      req_cycles = 0;
    end else if (sd_ack) begin
      sd_ack = 1'b0;
    end else if (stray_done != stray_req) begin
      sd_ack     = 1'b1;
      stray_done = stray_done + 1;
    end else if (sd_req && ack_enable) begin
      req_cycles = req_cycles + 1;
      if (req_cycles > ack_delay) begin
        sd_ack     = 1'b1;
        req_cycles = 0;
        log_addr.push_back(32'(sd_addr));
        log_din.push_back(32'(sd_din));
        log_be.push_back(32'(sd_be));
        $display("txn %0d: sd_addr=%06h sd_din=%04h sd_be=%02b", log_addr.size() - 1,
                 sd_addr, sd_din, sd_be);
      end
    end else begin
      req_cycles = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_raw(input logic [AW-1:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    int w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    push_raw(a, d);
  endtask

  task automatic wait_idle(input int max_cycles);
    int w = 0;
    while ((busy || sd_req) && w < max_cycles) begin
      tick();
      w++;
    end
    chk("idle_timeout", 32'(busy | sd_req), 32'd0);
    tick();
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    log_be.delete();
  endtask

  task automatic expect_txn(input int idx, input logic [31:0] a, input logic [31:0] din,
                            input logic [31:0] be);
    if (idx >= log_addr.size()) begin
      chk($sformatf("txn%0d.present", idx), 32'(log_addr.size()), 32'(idx + 1));
    end else begin
      chk($sformatf("txn%0d.addr", idx), log_addr[idx], a);
      chk($sformatf("txn%0d.din", idx), log_din[idx], din);
      chk($sformatf("txn%0d.be", idx), log_be[idx], be);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dl, dh;
    resetn  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.sd_req", 32'(sd_req), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.sd_be", 32'(sd_be), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // 1: single odd byte, ack 3 cycles after req, req two cycles after the push cycle
    ack_delay = 3;
    clear_log();
    push(22'h000011, 8'hA5);
    chk("t1.req_n1", 32'(sd_req), 32'd0);
    chk("t1.busy", 32'(busy), 32'd1);
    tick();
    chk("t1.req_n2", 32'(sd_req), 32'd1);
    chk("t1.sd_addr", 32'(sd_addr), 32'h000008);
    wait_idle(50);
    chk("t1.count", 32'(log_addr.size()), 32'd1);
    expect_txn(0, 32'h000008, 32'hA5A5, 32'b10);

    // 2: pair queued behind an outstanding request merges into one word write
    ack_delay = 4;
    clear_log();
    push(22'h000200, 8'h55);
    push(22'h000100, 8'h12);
    push(22'h000101, 8'h34);
    wait_idle(80);
    chk("t2.count", 32'(log_addr.size()), 32'd2);
    expect_txn(0, 32'h000100, 32'h5555, 32'b01);
    expect_txn(1, 32'h000080, 32'h3412, 32'b11);

    // 3: non-mergeable neighbours: odd head, word boundary, address wrap, gap
    ack_delay = 2;
    clear_log();
    push(22'h000300, 8'h99);
    push(22'h000101, 8'h77);
    push(22'h000102, 8'h88);
    push(22'h3FFFFF, 8'h11);
    push(22'h000000, 8'h22);
    push(22'h000204, 8'h33);
    push(22'h000206, 8'h44);
    wait_idle(200);
    chk("t3.count", 32'(log_addr.size()), 32'd7);
    expect_txn(0, 32'h000180, 32'h9999, 32'b01);
    expect_txn(1, 32'h000080, 32'h7777, 32'b10);
    expect_txn(2, 32'h000081, 32'h8888, 32'b01);
    expect_txn(3, 32'h1FFFFF, 32'h1111, 32'b10);
    expect_txn(4, 32'h000000, 32'h2222, 32'b01);
    expect_txn(5, 32'h000102, 32'h3333, 32'b01);
    expect_txn(6, 32'h000103, 32'h4444, 32'b01);

    // 4: backpressure with ack withheld; ninth byte is dropped
    ack_enable = 1'b0;
    ack_delay  = 1;
    clear_log();
    for (int i = 0; i < DEPTH; i++) begin
      push(AW'(22'h001001 + 2 * i), 8'(8'hC0 + i));
    end
    chk("t4.in_ready_full", 32'(in_ready), 32'd0);
    chk("t4.ovf_before", 32'(overflow), 32'd0);
    push_raw(22'h002001, 8'hEE);
    chk("t4.ovf_set", 32'(overflow), 32'd1);
    repeat (5) tick();
    chk("t4.ovf_sticky", 32'(overflow), 32'd1);
    chk("t4.in_ready_hold", 32'(in_ready), 32'd0);
    ack_enable = 1'b1;
    wait_idle(200);
    chk("t4.count", 32'(log_addr.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      expect_txn(i, 32'h000800 + 32'(i), {16'h0, 8'(8'hC0 + i), 8'(8'hC0 + i)}, 32'b10);
    end
    chk("t4.ovf_after", 32'(overflow), 32'd1);

    // 5: reset while a request is outstanding, then a stray ack in IDLE
    ack_enable = 1'b0;
    clear_log();
    push(22'h000400, 8'h5A);
    for (int w = 0; w < 20 && !sd_req; w++) tick();
    chk("t5.req_up", 32'(sd_req), 32'd1);
    resetn = 1'b0;
    tick();
    chk("t5.rst_req", 32'(sd_req), 32'd0);
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_ovf", 32'(overflow), 32'd0);
    chk("t5.rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    stray_req = stray_req + 1;
    repeat (3) tick();
    chk("t5.stray_busy", 32'(busy), 32'd0);
    chk("t5.stray_req", 32'(sd_req), 32'd0);
    chk("t5.stray_in_ready", 32'(in_ready), 32'd1);
    ack_enable = 1'b1;
    ack_delay  = 0;
    push(22'h000402, 8'h6B);
    wait_idle(50);
    chk("t5.count", 32'(log_addr.size()), 32'd1);
    expect_txn(0, 32'h000201, 32'h6B6B, 32'b01);

    // 6: streaming 64 sequential bytes behind a primer write
    ack_delay = 1;
    clear_log();
    push(22'h100000, 8'hF0);
    for (int i = 0; i < 64; i++) begin
      push(AW'(22'h200000 + i), 8'(i) ^ 8'h5A);
    end
    wait_idle(1000);
    chk("t6.count", 32'(log_addr.size()), 32'd33);
    expect_txn(0, 32'h080000, 32'hF0F0, 32'b01);
    for (int k = 0; k < 32; k++) begin
      dl = 8'(2 * k) ^ 8'h5A;
      dh = 8'(2 * k + 1) ^ 8'h5A;
      expect_txn(k + 1, 32'h100000 + 32'(k), {16'h0, dh, dl}, 32'b11);
    end
    chk("t6.ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
